// File: rtl/lcd_cmd_seq.sv
// Table-driven LCD controller command sequencer: issues stored commands with busy handshake and per-step dwell.
// Define LCD_SEQ_ACK_TIMEOUT_EN to add a watchdog that faults when busy never acknowledges a command.
module lcd_cmd_seq #(
    parameter int CMD_W   = 3,
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 24,
    parameter int ACK_TO  = 16,
    localparam int STEP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [STEP_W-1:0]  last_step,
    input  logic [STEP_W-1:0]  loop_start,
    input  logic               tbl_we,
    input  logic [STEP_W-1:0]  tbl_addr,
    input  logic [CMD_W-1:0]   tbl_cmd,
    input  logic [DWELL_W-1:0] tbl_dwell,
    output logic [CMD_W-1:0]   command,
    output logic               valid_in,
    input  logic               busy,
    input  logic               error,
    output logic [STEP_W-1:0]  cur_step,
    output logic               running,
    output logic               done,
    output logic               seq_err
);

    typedef enum logic [2:0] {
        IDLE, ARM, ISSUE, WAIT_ACK, WAIT_DONE, DWELL, ADV, FAULT
    } state_t;

    localparam logic [STEP_W-1:0] MAX_STEP = STEP_W'(DEPTH - 1);

    if (ACK_TO < 2) begin : g_bad_ack_to
        $error("ACK_TO must be at least 2");
    end

    state_t state, state_nxt;

    logic [CMD_W-1:0]   tbl_cmd_q   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell_q [DEPTH];
    logic [CMD_W-1:0]   cmd_lat;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [STEP_W-1:0]  last_eff;
    logic [STEP_W-1:0]  loop_eff;
    logic               at_last;
    logic               dwell_end;
    logic               err_set;
    logic               done_set;

    assign last_eff  = (last_step > MAX_STEP) ? MAX_STEP : last_step;
    assign loop_eff  = (loop_start > last_eff) ? '0 : loop_start;
    assign at_last   = (cur_step >= last_eff);
    assign dwell_end = (dwell_cnt == '0) || (dwell_cnt == DWELL_W'(1));

`ifdef LCD_SEQ_ACK_TIMEOUT_EN
    localparam int ACK_W = $clog2(ACK_TO + 1);

    logic [ACK_W-1:0] ack_cnt;
    logic             ack_expired;

    // Counts cycles since the valid_in pulse, so expiry lands ACK_TO cycles after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state == ISSUE) begin
            ack_cnt <= ACK_W'(1);
        end else if (state == WAIT_ACK) begin
            ack_cnt <= ack_cnt + ACK_W'(1);
        end
    end

    assign ack_expired = (ack_cnt == ACK_W'(ACK_TO - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        done_set  = 1'b0;
        if (state != IDLE && stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) state_nxt = ARM;
                ARM:       if (!busy) state_nxt = ISSUE;
                ISSUE:     state_nxt = WAIT_ACK;
                WAIT_ACK: begin
                    if (error) begin
                        state_nxt = FAULT;
                        err_set   = 1'b1;
                    end else if (busy) begin
                        state_nxt = WAIT_DONE;
`ifdef LCD_SEQ_ACK_TIMEOUT_EN
                    end else if (ack_expired) begin
                        state_nxt = FAULT;
                        err_set   = 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (error) begin
                        state_nxt = FAULT;
                        err_set   = 1'b1;
                    end else if (!busy) begin
                        state_nxt = DWELL;
                    end
                end
                DWELL:     if (dwell_end) state_nxt = ADV;
                ADV: begin
                    if (at_last && !loop_en) begin
                        state_nxt = IDLE;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = ARM;
                    end
                end
                FAULT:     if (!busy) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        command = '0;
        case (state)
            ISSUE:               command = tbl_cmd_q[cur_step];
            WAIT_ACK, WAIT_DONE: command = cmd_lat;
            default:             command = '0;
        endcase
    end

    assign valid_in = (state == ISSUE);
    assign running  = (state != IDLE);

    // Step fields are captured at ISSUE so table writes mid-step wait for the next issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_step  <= '0;
            cmd_lat   <= '0;
            dwell_cnt <= '0;
            seq_err   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_set;
            if (state == IDLE && start) begin
                cur_step <= '0;
                seq_err  <= 1'b0;
            end else if (err_set) begin
                seq_err <= 1'b1;
            end
            if (state == ISSUE) begin
                cmd_lat   <= tbl_cmd_q[cur_step];
                dwell_cnt <= tbl_dwell_q[cur_step];
            end else if (state == DWELL && state_nxt == DWELL) begin
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
            if (state == ADV && state_nxt == ARM) begin
                cur_step <= at_last ? loop_eff : cur_step + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_cmd_q[i]   <= '0;
                tbl_dwell_q[i] <= '0;
            end
        end else if (tbl_we && (int'(tbl_addr) < DEPTH)) begin
            tbl_cmd_q[tbl_addr]   <= tbl_cmd;
            tbl_dwell_q[tbl_addr] <= tbl_dwell;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed self-checking bench for lcd_cmd_seq with a simple busy-for-4-cycles controller model.
module tb_lcd_cmd_seq;

    localparam int CMD_W   = 3;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 24;
    localparam int ACK_TO  = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, stop, loop_en, tbl_we, error;
    logic [2:0]   last_step, loop_start, tbl_addr, tbl_cmd;
    logic [23:0]  tbl_dwell;
    logic [2:0]   command, cur_step;
    logic         valid_in, running, done, seq_err;
    logic         busy;
    logic         busy_mdl = 1'b0;
    logic         busy_force = 1'b0;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    bit  mdl_en   = 1'b1;
    int  mcnt     = 0;
    int  vcmd[$];
    int  vcyc[$];
    int  done_n   = 0;
    int  done_cyc = 0;

    assign busy = busy_mdl | busy_force;

    lcd_cmd_seq #(
        .CMD_W   (CMD_W),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W),
        .ACK_TO  (ACK_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_step  (last_step),
        .loop_start (loop_start),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_cmd    (tbl_cmd),
        .tbl_dwell  (tbl_dwell),
        .command    (command),
        .valid_in   (valid_in),
        .busy       (busy),
        .error      (error),
        .cur_step   (cur_step),
        .running    (running),
        .done       (done),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller: busy rises in the issue cycle and stays high for 4 cycles.
    always @(negedge clk) begin
        if (!mdl_en || rst) mcnt = 0;
        else if (valid_in) mcnt = 4;
        else if (mcnt > 0) mcnt = mcnt - 1;
        busy_mdl = (mcnt > 0);
    end

    always @(negedge clk) begin
        if (valid_in) begin
            vcmd.push_back(int'(command));
            vcyc.push_back(cyc);
        end
        if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic wr_tbl(input logic [2:0] a, input logic [2:0] c, input logic [23:0] d);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = a; tbl_cmd = c; tbl_dwell = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    task automatic pulse_start(output int t);
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_issue(input int step, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (valid_in && int'(cur_step) == step) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!running) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts;
        int d0;
        int n;
        bit ok;
        int exp_b[6] = '{1, 2, 5, 2, 5, 2};

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tbl_we = 1'b0; error = 1'b0;
        last_step = 3'd0; loop_start = 3'd0; tbl_addr = 3'd0; tbl_cmd = 3'd0; tbl_dwell = 24'd0;
        repeat (2) @(negedge clk);
        check("rst_command", int'(command), 0);
        check("rst_valid", int'(valid_in), 0);
        check("rst_cur_step", int'(cur_step), 0);
        check("rst_running", int'(running), 0);
        check("rst_done", int'(done), 0);
        check("rst_seq_err", int'(seq_err), 0);
        rst = 1'b0;

        // Single pass: 1 (d=0), 2 (d=3), 5 (d=0)
        wr_tbl(3'd0, 3'd1, 24'd0);
        wr_tbl(3'd1, 3'd2, 24'd3);
        wr_tbl(3'd2, 3'd5, 24'd0);
        last_step = 3'd2; loop_en = 1'b0; loop_start = 3'd0;
        vcmd.delete(); vcyc.delete(); d0 = done_n;
        pulse_start(ts);
        wait_idle(100, ok);
        check("a_idle_to", int'(ok), 1);
        @(negedge clk);
        check("a_nvalid", vcmd.size(), 3);
        if (vcmd.size() == 3) begin
            check("a_cmd0", vcmd[0], 1);
            check("a_cmd1", vcmd[1], 2);
            check("a_cmd2", vcmd[2], 5);
            check("a_start_lat", vcyc[0] - ts, 2);
            check("a_gap01", vcyc[1] - vcyc[0], 8);
            check("a_gap12", vcyc[2] - vcyc[1], 10);
            check("a_done_lat", done_cyc - vcyc[2], 7);
        end
        check("a_done_n", done_n - d0, 1);
        check("a_cur_step", int'(cur_step), 2);
        check("a_cmd_idle", int'(command), 0);
        check("a_running", int'(running), 0);

        // Looping with loop_start=1
        loop_en = 1'b1; loop_start = 3'd1;
        vcmd.delete(); vcyc.delete(); d0 = done_n;
        pulse_start(ts);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vcmd.size() >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_loop_to", int'(ok), 1);
        if (vcmd.size() >= 6) begin
            for (int i = 0; i < 6; i++) check($sformatf("b_cmd%0d", i), vcmd[i], exp_b[i]);
        end
        pulse_stop();
        check("b_stop_running", int'(running), 0);
        check("b_valid_after_stop", int'(valid_in), 0);
        check("b_done_n", done_n - d0, 0);

        // Error during WAIT_DONE of step 1
        loop_en = 1'b0; loop_start = 3'd0;
        vcmd.delete(); vcyc.delete(); d0 = done_n;
        pulse_start(ts);
        wait_issue(1, 60, ok);
        check("c_issue_to", int'(ok), 1);
        @(negedge clk);
        @(negedge clk);
        error = 1'b1;
        @(negedge clk);
        error = 1'b0;
        check("c_seq_err", int'(seq_err), 1);
        check("c_fault_running", int'(running), 1);
        check("c_fault_command", int'(command), 0);
        @(negedge clk);
        check("c_fault_hold", int'(running), 1);
        @(negedge clk);
        check("c_fault_exit", int'(running), 0);
        repeat (30) @(negedge clk);
        check("c_nvalid", vcmd.size(), 2);
        check("c_seq_err_sticky", int'(seq_err), 1);
        check("c_done_n", done_n - d0, 0);

        // Stop during DWELL of step 1, then restart
        vcmd.delete(); vcyc.delete(); d0 = done_n;
        pulse_start(ts);
        check("d_start_clears_err", int'(seq_err), 0);
        check("d_running", int'(running), 1);
        wait_issue(1, 60, ok);
        check("d_issue_to", int'(ok), 1);
        repeat (6) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("d_stop_running", int'(running), 0);
        check("d_cur_step_kept", int'(cur_step), 1);
        repeat (20) @(negedge clk);
        check("d_nvalid", vcmd.size(), 2);
        check("d_done_n", done_n - d0, 0);
        pulse_start(ts);
        wait_issue(0, 10, ok);
        check("d_restart_to", int'(ok), 1);
        check("d_restart_cmd", int'(command), 1);
        wait_idle(100, ok);
        check("d_idle_to", int'(ok), 1);
        @(negedge clk);
        check("d_restart_done_n", done_n - d0, 1);

        // Busy at start holds ARM; async reset in WAIT_DONE of step 1
        vcmd.delete(); vcyc.delete();
        @(negedge clk);
        busy_force = 1'b1;
        pulse_start(ts);
        repeat (5) @(negedge clk);
        check("e_arm_nvalid", vcmd.size(), 0);
        check("e_arm_valid", int'(valid_in), 0);
        check("e_arm_running", int'(running), 1);
        busy_force = 1'b0;
        @(negedge clk);
        check("e_issue_valid", int'(valid_in), 1);
        check("e_issue_cmd", int'(command), 1);
        wait_issue(1, 40, ok);
        check("e_issue1_to", int'(ok), 1);
        @(negedge clk);
        @(negedge clk);
        check("e_wait_done_cmd", int'(command), 2);
        #2 rst = 1'b1;
        #1;
        check("e_rst_command", int'(command), 0);
        check("e_rst_valid", int'(valid_in), 0);
        check("e_rst_cur_step", int'(cur_step), 0);
        check("e_rst_running", int'(running), 0);
        check("e_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse_start(ts);
        wait_issue(0, 10, ok);
        check("e_tbl_rst_to", int'(ok), 1);
        check("e_tbl_rst_cmd", int'(command), 0);
        wait_idle(100, ok);
        check("e_idle_to", int'(ok), 1);

        // Controller never acknowledges
        mdl_en = 1'b0;
        wr_tbl(3'd0, 3'd3, 24'd0);
        vcmd.delete(); vcyc.delete();
        pulse_start(ts);
        wait_issue(0, 10, ok);
        check("f_issue_to", int'(ok), 1);
        check("f_issue_cmd", int'(command), 3);
`ifdef LCD_SEQ_ACK_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (seq_err) begin
                n = i;
                break;
            end
        end
        check("f_timeout_cyc", n, 16);
        check("f_fault_running", int'(running), 1);
        @(negedge clk);
        check("f_fault_exit", int'(running), 0);
`else
        n = 0;
        repeat (40) @(negedge clk);
        check("f_no_timeout_err", int'(seq_err), 0);
        check("f_still_waiting", int'(running), 1);
        check("f_nvalid", vcmd.size() + n, 1);
        pulse_stop();
        check("f_stop_running", int'(running), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
